// File: rtl/contador_mod_n.sv
// Up/down modulo-MODULO counter with synchronous clear and clamped load.
// Free-runs with wrap, or with ONE_SHOT set halts at the terminal value until cleared or loaded.
module contador_mod_n #(
   parameter int N        = 8,
   parameter int MODULO   = 256,
   parameter int ONE_SHOT = 0
) (
   input  logic         clk_reloj,
   input  logic         rst_reset,
   input  logic         clr_sync,
   input  logic         ld_load,
   input  logic [N-1:0] d_dato,
   input  logic         en_enable,
   input  logic         up_dn,
   output logic [N-1:0] q,
   output logic         tc,
   output logic         wrap,
   output logic         done
);

   typedef enum logic [0:0] {
      ST_COUNT = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   localparam logic [N-1:0] MAX_VAL = N'(MODULO - 1);
   localparam logic [N:0]   MOD_EXT = (N+1)'(MODULO);

   state_t         state_q, state_d;
   logic [N-1:0]   count_q, count_d;
   logic           wrap_q, wrap_d;
   logic           done_q, done_d;
   logic [N-1:0]   term_s;
   logic [N-1:0]   ld_val_s;
   logic           tc_s;

   // Terminal value follows the direction input on the same cycle; load values clamp to MAX_VAL.
   always_comb begin
      term_s   = up_dn ? MAX_VAL : {N{1'b0}};
      ld_val_s = ({1'b0, d_dato} >= MOD_EXT) ? MAX_VAL : d_dato;
      tc_s     = en_enable & (count_q == term_s) & ~done_q;
   end

   // Next-state: clear beats load beats count; a consumed tc always produces a wrap pulse.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      wrap_d  = 1'b0;
      done_d  = done_q;
      if (clr_sync) begin
         state_d = ST_COUNT;
         count_d = {N{1'b0}};
         done_d  = 1'b0;
      end else if (ld_load) begin
         state_d = ST_COUNT;
         count_d = ld_val_s;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_COUNT: begin
               if (en_enable) begin
                  if (tc_s) begin
                     wrap_d = 1'b1;
                     if (ONE_SHOT != 0) begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                     end else begin
                        count_d = up_dn ? {N{1'b0}} : MAX_VAL;
                     end
                  end else begin
                     count_d = up_dn ? (count_q + N'(1)) : (count_q - N'(1));
                  end
               end else begin
                  count_d = count_q;
               end
            end
            ST_HOLD: begin
               count_d = count_q;
            end
            default: begin
               state_d = ST_COUNT;
               count_d = {N{1'b0}};
               done_d  = 1'b0;
            end
         endcase
      end
   end

   // State, count and status flops.
   always_ff @(posedge clk_reloj or negedge rst_reset) begin
      if (!rst_reset) begin
         state_q <= ST_COUNT;
         count_q <= {N{1'b0}};
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
      end
   end

   assign q    = count_q;
   assign tc   = tc_s;
   assign wrap = wrap_q;
   assign done = done_q;

endmodule

// File: tb/tb_contador_mod_n.sv
// Bench: a free-running (M=10) and a one-shot (M=6) counter share stimulus and are
// checked every cycle against an arithmetic reference model.
module tb_contador_mod_n;

   localparam int MA = 10;
   localparam int MB = 6;

   logic       clk;
   logic       rst;
   logic       clr;
   logic       ld;
   logic [3:0] d;
   logic       en;
   logic       up;
   logic [3:0] q_a, q_b;
   logic       tc_a, tc_b, wrap_a, wrap_b, done_a, done_b;

   int errors = 0;
   int checks = 0;

   int mq_a, mq_b;
   bit mdone_a, mdone_b, mwrap_a, mwrap_b;

   contador_mod_n #(.N(4), .MODULO(MA), .ONE_SHOT(0)) dut_a (
      .clk_reloj(clk), .rst_reset(rst), .clr_sync(clr), .ld_load(ld), .d_dato(d),
      .en_enable(en), .up_dn(up), .q(q_a), .tc(tc_a), .wrap(wrap_a), .done(done_a)
   );

   contador_mod_n #(.N(4), .MODULO(MB), .ONE_SHOT(1)) dut_b (
      .clk_reloj(clk), .rst_reset(rst), .clr_sync(clr), .ld_load(ld), .d_dato(d),
      .en_enable(en), .up_dn(up), .q(q_b), .tc(tc_b), .wrap(wrap_b), .done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic bit model_tc(input int m, input int mq, input bit mdone);
      int term;
      term = up ? (m - 1) : 0;
      return en && !mdone && (mq == term);
   endfunction

   // Reference behaviour of one edge, from the counter's rules in plain arithmetic.
   task automatic model_step(input int m, input bit os, input int q_in, input bit done_in,
                             output int q_out, output bit done_out, output bit wrap_out);
      bit hit;
      q_out    = q_in;
      done_out = done_in;
      wrap_out = 1'b0;
      hit      = model_tc(m, q_in, done_in);
      if (clr) begin
         q_out    = 0;
         done_out = 1'b0;
      end else if (ld) begin
         q_out    = (int'(d) >= m) ? (m - 1) : int'(d);
         done_out = 1'b0;
      end else if (en && !done_in) begin
         wrap_out = hit;
         if (os && hit) done_out = 1'b1;
         else q_out = up ? (q_in + 1) % m : (q_in + m - 1) % m;
      end
   endtask

   task automatic model_reset();
      mq_a = 0; mq_b = 0;
      mdone_a = 1'b0; mdone_b = 1'b0;
      mwrap_a = 1'b0; mwrap_b = 1'b0;
   endtask

   // One clock: tc before the edge, registered outputs just after it.
   task automatic do_cycle();
      #1;
      chk("tc_a", tc_a, model_tc(MA, mq_a, mdone_a));
      chk("tc_b", tc_b, model_tc(MB, mq_b, mdone_b));
      @(posedge clk);
      model_step(MA, 1'b0, mq_a, mdone_a, mq_a, mdone_a, mwrap_a);
      model_step(MB, 1'b1, mq_b, mdone_b, mq_b, mdone_b, mwrap_b);
      #1;
      chk("q_a", q_a, mq_a);
      chk("wrap_a", wrap_a, mwrap_a);
      chk("done_a", done_a, mdone_a);
      chk("q_b", q_b, mq_b);
      chk("wrap_b", wrap_b, mwrap_b);
      chk("done_b", done_b, mdone_b);
      chk("q_a_range", (int'(q_a) < MA), 1);
      chk("q_b_range", (int'(q_b) < MB), 1);
      @(negedge clk);
   endtask

   task automatic set_in(input bit c, input bit l, input logic [3:0] dv, input bit e, input bit u);
      clr = c; ld = l; d = dv; en = e; up = u;
   endtask

   initial begin
      rst = 1'b0;
      set_in(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      model_reset();
      #1;
      chk("reset_q_a", q_a, 0);
      chk("reset_wrap_a", wrap_a, 0);
      chk("reset_done_b", done_b, 0);
      chk("reset_q_b", q_b, 0);
      @(negedge clk);
      rst = 1'b1;

      // Up count, 12 cycles
      set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) do_cycle();
      chk("up12_q_a", q_a, 2);
      chk("oneshot_stop_q_b", q_b, 5);
      chk("oneshot_done_b", done_b, 1);

      // Down from 0 wraps to MODULO-1
      set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      do_cycle();
      set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      do_cycle();
      chk("down_wrap_q_a", q_a, 9);
      chk("down_wrap_pulse_a", wrap_a, 1);
      set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      do_cycle();
      chk("down_wrap_single_a", wrap_a, 0);

      // Clamped load; load beats enable
      set_in(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
      do_cycle();
      chk("clamp_q_a", q_a, 9);
      set_in(1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
      do_cycle();
      chk("load_en_q_a", q_a, 3);

      // One-shot: run to stop, then reload 2 and resume
      set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      do_cycle();
      set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) do_cycle();
      chk("os_halt_q_b", q_b, 5);
      set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      do_cycle();
      chk("os_hold_ignores_dir_q_b", q_b, 5);
      set_in(1'b0, 1'b1, 4'd2, 1'b0, 1'b1);
      do_cycle();
      chk("os_reload_done_b", done_b, 0);
      set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) do_cycle();
      chk("os_resume_q_b", q_b, 5);

      // Asynchronous reset between edges at q=7
      set_in(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
      do_cycle();
      set_in(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) do_cycle();
      chk("pre_rst_q_a", q_a, 7);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_q_a", q_a, 0);
      chk("async_rst_wrap_a", wrap_a, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      do_cycle();
      chk("post_rst_q_a", q_a, 1);

      // Clear together with load
      set_in(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
      do_cycle();
      chk("clr_ld_q_a", q_a, 0);

      // Random regression
      for (int i = 0; i < 600; i++) begin
         set_in(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                4'($urandom_range(0, 15)), ($urandom_range(0, 4) != 0),
                ($urandom_range(0, 2) != 0));
         do_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
